// File: rtl/prim_bus_arbiter.sv
// Two-master round-robin arbiter for the Prim 16-bit ack-terminated memory bus.
// Optional slave-timeout abort is compiled in with `define PRIM_ARB_TIMEOUT_EN.
module prim_bus_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [AW-1:0]     i_m0_addr,
  input  logic [DW-1:0]     i_m0_dat,
  input  logic [DW/8-1:0]   i_m0_bs,
  input  logic              i_m0_we,
  input  logic              i_m0_cs,
  input  logic [AW-1:0]     i_m1_addr,
  input  logic [DW-1:0]     i_m1_dat,
  input  logic [DW/8-1:0]   i_m1_bs,
  input  logic              i_m1_we,
  input  logic              i_m1_cs,
  output logic [DW-1:0]     o_m0_dat,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  output logic [DW-1:0]     o_m1_dat,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic [AW-1:0]     o_addr,
  output logic [DW-1:0]     o_dat,
  output logic [DW/8-1:0]   o_bs,
  output logic              o_we,
  output logic              o_cs,
  input  logic [DW-1:0]     i_dat,
  input  logic              i_ack,
  output logic [1:0]        o_grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state;
  logic   last;
  logic   own0, own1;
  logic   cur_cs;
  logic   to_hit;

  assign own0   = (state == OWN0);
  assign own1   = (state == OWN1);
  assign cur_cs = own0 ? i_m0_cs : (own1 ? i_m1_cs : 1'b0);

`ifdef PRIM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // cnt counts owned cycles already elapsed, so the abort lands on owned cycle TIMEOUT
  assign to_hit = (own0 | own1) & cur_cs & ~i_ack & (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)          cnt <= '0;
    else if (state == IDLE)  cnt <= '0;
    else if (!i_ack)         cnt <= cnt + 1'b1;
  end

  assign o_m0_err = own0 & to_hit;
  assign o_m1_err = own1 & to_hit;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT;
  assign to_hit   = 1'b0;
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      o_grant <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (i_m0_cs && (!i_m1_cs || last)) begin
            state   <= OWN0;
            o_grant <= 2'b01;
          end else if (i_m1_cs) begin
            state   <= OWN1;
            o_grant <= 2'b10;
          end
        end
        OWN0: begin
          if (!i_m0_cs || i_ack || to_hit) begin
            state   <= IDLE;
            last    <= 1'b0;
            o_grant <= 2'b00;
          end
        end
        OWN1: begin
          if (!i_m1_cs || i_ack || to_hit) begin
            state   <= IDLE;
            last    <= 1'b1;
            o_grant <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= 2'b00;
        end
      endcase
    end
  end

  // Slave side follows the registered owner; nothing leaks out while idle
  always_comb begin
    o_addr = '0;
    o_dat  = '0;
    o_bs   = '0;
    o_we   = 1'b0;
    if (own0) begin
      o_addr = i_m0_addr;
      o_dat  = i_m0_dat;
      o_bs   = i_m0_bs;
      o_we   = i_m0_we;
    end else if (own1) begin
      o_addr = i_m1_addr;
      o_dat  = i_m1_dat;
      o_bs   = i_m1_bs;
      o_we   = i_m1_we;
    end
  end

  assign o_cs     = cur_cs & ~to_hit;
  assign o_m0_ack = own0 & i_m0_cs & (i_ack | to_hit);
  assign o_m1_ack = own1 & i_m1_cs & (i_ack | to_hit);
  assign o_m0_dat = (own0 & ~to_hit) ? i_dat : '0;
  assign o_m1_dat = (own1 & ~to_hit) ? i_dat : '0;

endmodule
